// File: rtl/rvfi_mon_pkg.sv
// rvfi_mon_pkg: shared types and cause priority for the commit/halt monitor.
//   halt_cause_t : 2-bit halt cause code (NONE, SENTINEL, LOOP, TIMEOUT)
//   mon_state_t  : monitor FSM states (RUN, HALT_PEND, HALTED)
//   pick_cause() : resolves simultaneous halt conditions by priority
package rvfi_mon_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_SENTINEL = 2'd1,
        CAUSE_LOOP     = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } halt_cause_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT_PEND,
        ST_HALTED
    } mon_state_t;

    localparam halt_cause_t PRIO_HI  = CAUSE_SENTINEL;
    localparam halt_cause_t PRIO_MID = CAUSE_LOOP;
    localparam halt_cause_t PRIO_LO  = CAUSE_TIMEOUT;

    function automatic halt_cause_t pick_cause(input logic hi, input logic mid, input logic lo);
        return hi ? PRIO_HI : mid ? PRIO_MID : lo ? PRIO_LO : CAUSE_NONE;
    endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// lane_prefix_count: exclusive prefix popcount of per-lane valid bits.
//   valid  : one bit per lane, lane 0 oldest
//   prefix : per lane, number of valid lanes strictly below it (CW bits each)
//   total  : number of valid lanes
module lane_prefix_count #(
    parameter int NUM_CH = 2,
    parameter int CW     = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]    valid,
    output logic [NUM_CH*CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            prefix[i*CW +: CW] = acc;
            acc                = acc + CW'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/commit_halt_monitor.sv
// commit_halt_monitor: assigns program-order indices to per-cycle commits and
// raises a sticky halt on sentinel match, self-looping PC or idle timeout.
//   clk, rst            : clock, synchronous active-low reset
//   commit_valid/pc/..  : NUM_CH in-order commit lanes, lane 0 oldest
//   watch_data/en       : watched register values compared against sentinel
//   lane_order          : combinational order index per lane
//   order_q, idle_cnt   : commits accepted so far, consecutive idle cycles
//   halt, halt_cause    : sticky halt and its latched cause
module commit_halt_monitor
    import rvfi_mon_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int XLEN        = 32,
    parameter int ORDER_W     = 64,
    parameter int NUM_WATCH   = 3,
    parameter int LOOP_THRESH = 4,
    parameter int TIMEOUT     = 100000,
    parameter int IDLE_W      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         commit_valid,
    input  logic [NUM_CH*XLEN-1:0]    commit_pc,
    input  logic [NUM_CH*XLEN-1:0]    commit_pc_next,
    input  logic [NUM_WATCH*XLEN-1:0] watch_data,
    input  logic [NUM_WATCH-1:0]      watch_en,
    input  logic [XLEN-1:0]           sentinel,
    output logic [NUM_CH*ORDER_W-1:0] lane_order,
    output logic [ORDER_W-1:0]        order_q,
    output logic [IDLE_W-1:0]         idle_cnt,
    output logic                      halt,
    output logic [1:0]                halt_cause
);

    localparam int CW = $clog2(NUM_CH + 1);
    localparam int LW = $clog2(LOOP_THRESH + 1);
    localparam logic [IDLE_W-1:0] TMO_LAST = IDLE_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    mon_state_t           state, state_nx;
    halt_cause_t          cause, cause_nx;
    logic [LW-1:0]        loop_cnt, loop_nx;
    logic [NUM_CH*CW-1:0] prefix;
    logic [CW-1:0]        total;
    logic                 any_commit, accept, sent_hit, loop_hit, tmo_hit;

    lane_prefix_count #(.NUM_CH(NUM_CH), .CW(CW)) u_prefix (
        .valid  (commit_valid),
        .prefix (prefix),
        .total  (total)
    );

    assign any_commit = |commit_valid;
    assign accept     = state != ST_HALTED;
    assign halt       = state == ST_HALTED;
    assign halt_cause = cause;
    // The TIMEOUT-th idle cycle is the one that finds idle_cnt at TIMEOUT-1.
    assign tmo_hit    = (TIMEOUT != 0) && !any_commit && idle_cnt == TMO_LAST;
    assign loop_hit   = any_commit && loop_nx >= LW'(LOOP_THRESH);

    always_comb begin
        lane_order = '0;
        for (int i = 0; i < NUM_CH; i++)
            lane_order[i*ORDER_W +: ORDER_W] = order_q + ORDER_W'(prefix[i*CW +: CW]);
    end

    // Walk lanes oldest first so the youngest valid lane decides the count.
    always_comb begin
        loop_nx = loop_cnt;
        for (int i = 0; i < NUM_CH; i++)
            if (commit_valid[i])
                loop_nx = (commit_pc[i*XLEN +: XLEN] == commit_pc_next[i*XLEN +: XLEN])
                        ? ((loop_nx == LW'(LOOP_THRESH)) ? loop_nx : loop_nx + 1'b1)
                        : '0;
    end

    always_comb begin
        sent_hit = 1'b0;
        for (int k = 0; k < NUM_WATCH; k++)
            sent_hit = sent_hit | (watch_en[k] && watch_data[k*XLEN +: XLEN] == sentinel);
    end

    always_comb begin
        state_nx = state;
        cause_nx = cause;
        case (state)
            ST_RUN: begin
                if (sent_hit || loop_hit || tmo_hit) begin
                    state_nx = ST_HALT_PEND;
                    cause_nx = pick_cause(sent_hit, loop_hit, tmo_hit);
                end
            end
            default: state_nx = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            cause    <= CAUSE_NONE;
            order_q  <= '0;
            idle_cnt <= '0;
            loop_cnt <= '0;
        end else begin
            state    <= state_nx;
            cause    <= cause_nx;
            idle_cnt <= any_commit ? '0 : (&idle_cnt ? idle_cnt : idle_cnt + 1'b1);
            if (accept) begin
                order_q  <= order_q + ORDER_W'(total);
                loop_cnt <= loop_nx;
            end
        end
    end

endmodule
